// File: rtl/tt_um_led_pattern_engine.sv
// LED pattern engine: a programmable prescaler produces step ticks, and each
// tick advances an 8-bit pattern (rotate, bounce, bar fill/drain or hold) and
// an 8-bit step counter. Controls arrive asynchronously on ui_in and are
// passed through a two-flop synchronizer before use.
module tt_um_led_pattern_engine #(
    parameter int               CNT_W      = 24,
    parameter logic [CNT_W-1:0] BASE_COUNT = CNT_W'(10_000_000),
    parameter logic [7:0]       SEED       = 8'b0000_0001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {
        BDIR_LEFT  = 1'b0,
        BDIR_RIGHT = 1'b1
    } bdir_t;

    typedef enum logic {
        PHASE_FILL  = 1'b0,
        PHASE_DRAIN = 1'b1
    } phase_t;

    logic [7:0]       sync_q, sync_d;
    logic [7:0]       ctl_q, ctl_d;
    logic [CNT_W-1:0] pc_q, pc_d;
    logic [7:0]       pat_q, pat_d;
    logic [7:0]       step_q, step_d;
    bdir_t            bdir_q, bdir_d;
    phase_t           phase_q, phase_d;

    logic [1:0]       mode;
    logic             dir;
    logic [2:0]       speed;
    logic             pause;
    logic             restart;
    logic [CNT_W-1:0] period_raw;
    logic [CNT_W-1:0] period_last;
    logic             tick;
    logic             one_hot;
    logic [7:0]       pat_step;
    bdir_t            bdir_step;
    phase_t           phase_step;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in};

    assign mode    = ctl_q[1:0];
    assign dir     = ctl_q[2];
    assign speed   = ctl_q[5:3];
    assign pause   = ctl_q[6];
    assign restart = ctl_q[7];

    assign uo_out  = pat_q;
    assign uio_out = step_q;
    assign uio_oe  = 8'hFF;

    // Step period for the current speed, clamped to one cycle; kept as period-1 for the compare.
    always_comb begin
        period_raw  = BASE_COUNT >> speed;
        period_last = (period_raw == '0) ? '0 : period_raw - CNT_W'(1);
        tick        = (pc_q >= period_last) && !pause;
        one_hot     = (pat_q != 8'h00) && ((pat_q & (pat_q - 8'd1)) == 8'h00);
    end

    // Pattern that the current mode would produce on the next tick.
    always_comb begin
        pat_step   = pat_q;
        bdir_step  = bdir_q;
        phase_step = phase_q;
        case (mode)
            2'b00: begin
                if (pat_q == 8'h00) begin
                    pat_step = SEED;
                end else if (!dir) begin
                    pat_step = {pat_q[6:0], pat_q[7]};
                end else begin
                    pat_step = {pat_q[0], pat_q[7:1]};
                end
            end
            2'b01: begin
                if (!one_hot) begin
                    pat_step  = 8'h01;
                    bdir_step = BDIR_LEFT;
                end else if (bdir_q == BDIR_LEFT) begin
                    if (pat_q == 8'h80) begin
                        pat_step  = 8'h40;
                        bdir_step = BDIR_RIGHT;
                    end else begin
                        pat_step = {pat_q[6:0], 1'b0};
                    end
                end else begin
                    if (pat_q == 8'h01) begin
                        pat_step  = 8'h02;
                        bdir_step = BDIR_LEFT;
                    end else begin
                        pat_step = {1'b0, pat_q[7:1]};
                    end
                end
            end
            2'b10: begin
                if (phase_q == PHASE_FILL) begin
                    if (pat_q == 8'hFF) begin
                        pat_step   = 8'hFE;
                        phase_step = PHASE_DRAIN;
                    end else begin
                        pat_step = {pat_q[6:0], 1'b1};
                    end
                end else begin
                    if (pat_q == 8'h00) begin
                        pat_step   = 8'h01;
                        phase_step = PHASE_FILL;
                    end else begin
                        pat_step = {pat_q[6:0], 1'b0};
                    end
                end
            end
            default: begin
                pat_step = pat_q;
            end
        endcase
    end

    // Next-state selection: restart behaves like reset, pause freezes everything.
    always_comb begin
        sync_d  = ui_in;
        ctl_d   = sync_q;
        pc_d    = pc_q;
        pat_d   = pat_q;
        step_d  = step_q;
        bdir_d  = bdir_q;
        phase_d = phase_q;
        if (restart) begin
            pc_d    = '0;
            pat_d   = SEED;
            step_d  = 8'h00;
            bdir_d  = BDIR_LEFT;
            phase_d = PHASE_FILL;
        end else if (tick) begin
            pc_d    = '0;
            pat_d   = pat_step;
            step_d  = step_q + 8'd1;
            bdir_d  = bdir_step;
            phase_d = phase_step;
        end else if (!pause) begin
            pc_d = pc_q + CNT_W'(1);
        end
    end

    // All state registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 8'h00;
            ctl_q   <= 8'h00;
            pc_q    <= '0;
            pat_q   <= SEED;
            step_q  <= 8'h00;
            bdir_q  <= BDIR_LEFT;
            phase_q <= PHASE_FILL;
        end else begin
            sync_q  <= sync_d;
            ctl_q   <= ctl_d;
            pc_q    <= pc_d;
            pat_q   <= pat_d;
            step_q  <= step_d;
            bdir_q  <= bdir_d;
            phase_q <= phase_d;
        end
    end

endmodule
